// File: rtl/norm_stats_pkg.sv
// norm_stats_pkg
// Shared sizes, Q8.8 constants and FSM state encoding for the batch
// statistics block (norm_stats) and its serial divider (norm_stats_div).
package norm_stats_pkg;

    // Tile geometry and element format
    localparam int DWIDTH           = 16;
    localparam int DESIGN_SIZE      = 32;
    localparam int MASK_WIDTH       = 32;
    localparam int LOG2_DESIGN_SIZE = 5;

    // Divider widths
    localparam int DIV_W  = 48;
    localparam int DVSR_W = 24;

    // Accumulator widths: 1024 elements of signed 16b / their squares
    localparam int SUM_W = 27;
    localparam int SQ_W  = 42;
    localparam int CNT_W = 11;

    // Q8.8 constants
    localparam logic [DWIDTH-1:0] Q88_ONE       = 16'h0100;
    localparam logic [DWIDTH-1:0] Q88_MAX       = 16'hFFFF;
    localparam logic [DIV_W-1:0]  Q88_RECIP_NUM = 48'd65536;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ACCUM    = 3'd1,
        ST_DIV_MEAN = 3'd2,
        ST_DIV_SQ   = 3'd3,
        ST_VAR      = 3'd4,
        ST_DIV_INV  = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

endpackage

// File: rtl/norm_stats_div.sv
// norm_stats_div
// Unsigned restoring divider, one quotient bit per clock.
// A start pulse loads the operands; the quotient is complete DIV_W cycles
// later and div_done pulses for one cycle. A new start aborts any divide in
// progress. Division by zero yields an all-ones quotient.
// Ports:
//   clk, reset (async, active-low)
//   start     - load operands and begin
//   dividend  - DIV_W-bit unsigned
//   divisor   - DVSR_W-bit unsigned
//   quotient  - DIV_W-bit unsigned result (valid when div_done)
//   div_done  - one-cycle completion pulse
module norm_stats_div
    import norm_stats_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DIV_W-1:0]  dividend,
    input  logic [DVSR_W-1:0] divisor,
    output logic [DIV_W-1:0]  quotient,
    output logic              div_done
);

    localparam int CW = $clog2(DIV_W + 1);

    logic [DIV_W-1:0]  r_q;      // dividend bits shift out, quotient bits shift in
    logic [DVSR_W-1:0] r_rem;
    logic [DVSR_W-1:0] r_dvsr;
    logic [CW-1:0]     r_cnt;
    logic              r_busy;
    logic              r_done;

    logic [DVSR_W:0]   w_rem_sh;
    logic [DVSR_W:0]   w_rem_sub;
    logic              w_ge;

    assign w_rem_sh  = {r_rem, r_q[DIV_W-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_dvsr});
    assign w_rem_sub = w_rem_sh - {1'b0, r_dvsr};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q    <= '0;
            r_rem  <= '0;
            r_dvsr <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (start) begin
            r_q    <= dividend;
            r_rem  <= '0;
            r_dvsr <= divisor;
            r_cnt  <= CW'(DIV_W);
            r_busy <= 1'b1;
            r_done <= 1'b0;
        end else if (r_busy) begin
            r_q <= {r_q[DIV_W-2:0], w_ge};
            // Remainder stays below the divisor, so the top bit is always
            // zero after the restore/subtract choice (except divide-by-zero,
            // where the remainder value is irrelevant).
            r_rem <= w_ge ? w_rem_sub[DVSR_W-1:0] : w_rem_sh[DVSR_W-1:0];
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign quotient = r_q;
    assign div_done = r_done;

endmodule

// File: rtl/norm_stats.sv
// norm_stats
// Accumulates sum and sum-of-squares of the masked lanes over one tile of
// DESIGN_SIZE columns, then derives the Q8.8 mean and Q8.8 inverse variance
// with a shared serial divider (mean, E[x^2], then 65536/var).
// Ports:
//   clk, reset (async, active-low)
//   enable_stats       - level enable; low returns to IDLE and clears results
//   in_data_available  - column valid
//   inp_data           - one column, lane i at [i*DWIDTH +: DWIDTH]
//   validity_mask      - lane include mask
//   mean               - signed Q8.8 mean
//   inv_var            - unsigned Q8.8 1/variance
//   stats_valid        - mean/inv_var valid
//   done_stats         - stats_valid, or 1 while bypassed (enable_stats=0)
module norm_stats
    import norm_stats_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable_stats,
    input  logic                          in_data_available,
    input  logic [DESIGN_SIZE*DWIDTH-1:0] inp_data,
    input  logic [MASK_WIDTH-1:0]         validity_mask,
    output logic [DWIDTH-1:0]             mean,
    output logic [DWIDTH-1:0]             inv_var,
    output logic                          stats_valid,
    output logic                          done_stats
);

    localparam int                      COL_W    = LOG2_DESIGN_SIZE + 1;
    localparam logic [COL_W-1:0]        LAST_COL = COL_W'(DESIGN_SIZE);

    state_t                    r_state;
    logic [COL_W-1:0]          r_col_cnt;
    logic signed [SUM_W-1:0]   r_sum;
    logic [SQ_W-1:0]           r_sumsq;
    logic [CNT_W-1:0]          r_count;
    logic [SQ_W-1:0]           r_ex2;
    logic signed [DWIDTH-1:0]  r_mean;
    logic [DWIDTH-1:0]         r_inv_var;
    logic                      r_stats_valid;

    logic signed [SUM_W-1:0]   w_col_sum;
    logic [SQ_W-1:0]           w_col_sq;
    logic [CNT_W-1:0]          w_pop;
    logic signed [SUM_W-1:0]   w_sum_nxt;
    logic [SQ_W-1:0]           w_sumsq_nxt;
    logic [CNT_W-1:0]          w_count_nxt;
    logic [COL_W-1:0]          w_col_nxt;
    logic [SUM_W-1:0]          w_abs_nxt;
    logic                      w_accept;
    logic                      w_last;

    logic                      w_div_start;
    logic [DIV_W-1:0]          w_div_dividend;
    logic [DVSR_W-1:0]         w_div_divisor;
    logic [DIV_W-1:0]          w_quot;
    logic                      w_div_done;

    logic [DWIDTH-1:0]         w_mean_q;
    logic signed [2*DWIDTH-1:0] w_msq;
    logic signed [SQ_W:0]      w_var_diff;
    logic [SQ_W-1:0]           w_var16;
    logic [DVSR_W-1:0]         w_var8;

    function automatic logic signed [SUM_W-1:0] sext_lane(input logic [DWIDTH-1:0] x);
        return {{(SUM_W-DWIDTH){x[DWIDTH-1]}}, x};
    endfunction

    function automatic logic [SQ_W-1:0] sq_lane(input logic [DWIDTH-1:0] x);
        logic signed [DWIDTH-1:0]   s;
        logic signed [2*DWIDTH-1:0] p;
        s = x;
        p = s * s;
        return {{(SQ_W-2*DWIDTH){1'b0}}, p};
    endfunction

    // Quotient to Q8.8 with saturation (65536/1 exceeds 16 bits)
    function automatic logic [DWIDTH-1:0] sat_u16(input logic [DIV_W-1:0] q);
        return (|q[DIV_W-1:DWIDTH]) ? Q88_MAX : q[DWIDTH-1:0];
    endfunction

    // var16 never exceeds 2^30 for legal inputs; saturate rather than wrap
    function automatic logic [DVSR_W-1:0] sat_var8(input logic [SQ_W-1:0] v);
        return (|v[SQ_W-1:8+DVSR_W]) ? {DVSR_W{1'b1}} : v[8 +: DVSR_W];
    endfunction

    // Column reduction over the masked lanes
    always_comb begin
        w_col_sum = '0;
        w_col_sq  = '0;
        w_pop     = '0;
        for (int i = 0; i < DESIGN_SIZE; i++) begin
            if (validity_mask[i]) begin
                w_col_sum = w_col_sum + sext_lane(inp_data[i*DWIDTH +: DWIDTH]);
                w_col_sq  = w_col_sq + sq_lane(inp_data[i*DWIDTH +: DWIDTH]);
                w_pop     = w_pop + CNT_W'(1);
            end
        end
    end

    // Accumulators are zero in IDLE, so IDLE and ACCUM share one update path
    assign w_accept    = in_data_available && (r_state == ST_IDLE || r_state == ST_ACCUM);
    assign w_sum_nxt   = r_sum + w_col_sum;
    assign w_sumsq_nxt = r_sumsq + w_col_sq;
    assign w_count_nxt = r_count + w_pop;
    assign w_col_nxt   = r_col_cnt + COL_W'(1);
    assign w_last      = w_accept && (w_col_nxt == LAST_COL);
    assign w_abs_nxt   = w_sum_nxt[SUM_W-1] ? $unsigned(-w_sum_nxt) : $unsigned(w_sum_nxt);

    // Mean: truncate toward zero by dividing the magnitude, then restore sign
    assign w_mean_q = r_sum[SUM_W-1] ? (~w_quot[DWIDTH-1:0] + DWIDTH'(1)) : w_quot[DWIDTH-1:0];

    // Variance in Q16.16, clamped at zero, then reduced to Q.8 for the divisor
    assign w_msq      = r_mean * r_mean;
    assign w_var_diff = $signed({1'b0, r_ex2}) - $signed({{(SQ_W+1-2*DWIDTH){1'b0}}, w_msq});
    assign w_var16    = w_var_diff[SQ_W] ? '0 : w_var_diff[SQ_W-1:0];
    assign w_var8     = sat_var8(w_var16);

    // Divider is launched on the edge that enters each DIV state, so its
    // completion pulse lands on the 49th cycle of that state.
    always_comb begin
        w_div_start    = 1'b0;
        w_div_dividend = '0;
        w_div_divisor  = '0;
        if (enable_stats) begin
            case (r_state)
                ST_IDLE, ST_ACCUM: begin
                    if (w_last && (w_count_nxt != '0)) begin
                        w_div_start    = 1'b1;
                        w_div_dividend = DIV_W'(w_abs_nxt);
                        w_div_divisor  = DVSR_W'(w_count_nxt);
                    end
                end
                ST_DIV_MEAN: begin
                    if (w_div_done) begin
                        w_div_start    = 1'b1;
                        w_div_dividend = DIV_W'(r_sumsq);
                        w_div_divisor  = DVSR_W'(r_count);
                    end
                end
                ST_VAR: begin
                    if (w_var8 != '0) begin
                        w_div_start    = 1'b1;
                        w_div_dividend = Q88_RECIP_NUM;
                        w_div_divisor  = w_var8;
                    end
                end
                default: ;
            endcase
        end
    end

    norm_stats_div u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (w_div_start),
        .dividend (w_div_dividend),
        .divisor  (w_div_divisor),
        .quotient (w_quot),
        .div_done (w_div_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_col_cnt     <= '0;
            r_sum         <= '0;
            r_sumsq       <= '0;
            r_count       <= '0;
            r_ex2         <= '0;
            r_mean        <= '0;
            r_inv_var     <= '0;
            r_stats_valid <= 1'b0;
        end else if (!enable_stats) begin
            // Abort has priority over everything, including a final column
            r_state       <= ST_IDLE;
            r_col_cnt     <= '0;
            r_sum         <= '0;
            r_sumsq       <= '0;
            r_count       <= '0;
            r_ex2         <= '0;
            r_mean        <= '0;
            r_inv_var     <= '0;
            r_stats_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_ACCUM: begin
                    if (in_data_available) begin
                        r_sum     <= w_sum_nxt;
                        r_sumsq   <= w_sumsq_nxt;
                        r_count   <= w_count_nxt;
                        r_col_cnt <= w_col_nxt;
                        r_state   <= ST_ACCUM;
                        if (w_last) begin
                            if (w_count_nxt == '0) begin
                                r_mean    <= '0;
                                r_inv_var <= Q88_ONE;
                                r_state   <= ST_DONE;
                            end else begin
                                r_state   <= ST_DIV_MEAN;
                            end
                        end
                    end
                end
                ST_DIV_MEAN: begin
                    if (w_div_done) begin
                        r_mean  <= w_mean_q;
                        r_state <= ST_DIV_SQ;
                    end
                end
                ST_DIV_SQ: begin
                    if (w_div_done) begin
                        r_ex2   <= w_quot[SQ_W-1:0];
                        r_state <= ST_VAR;
                    end
                end
                ST_VAR: begin
                    if (w_var8 == '0) begin
                        r_inv_var     <= Q88_MAX;
                        r_stats_valid <= 1'b1;
                        r_state       <= ST_DONE;
                    end else begin
                        r_state <= ST_DIV_INV;
                    end
                end
                ST_DIV_INV: begin
                    if (w_div_done) begin
                        r_inv_var     <= sat_u16(w_quot);
                        r_stats_valid <= 1'b1;
                        r_state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_stats_valid <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mean        = r_mean;
    assign inv_var     = r_inv_var;
    assign stats_valid = r_stats_valid;
    assign done_stats  = reset && (r_stats_valid || !enable_stats);

endmodule

// File: tb/tb_norm_stats.sv
module tb_norm_stats;
    import norm_stats_pkg::*;

    logic                          clk;
    logic                          reset;
    logic                          enable_stats;
    logic                          in_data_available;
    logic [DESIGN_SIZE*DWIDTH-1:0] inp_data;
    logic [MASK_WIDTH-1:0]         validity_mask;
    logic [DWIDTH-1:0]             mean;
    logic [DWIDTH-1:0]             inv_var;
    logic                          stats_valid;
    logic                          done_stats;

    norm_stats dut (
        .clk               (clk),
        .reset             (reset),
        .enable_stats      (enable_stats),
        .in_data_available (in_data_available),
        .inp_data          (inp_data),
        .validity_mask     (validity_mask),
        .mean              (mean),
        .inv_var           (inv_var),
        .stats_valid       (stats_valid),
        .done_stats        (done_stats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] m;
        logic [15:0] iv;
        int          lat;
        int          e0;
    } exp_t;

    exp_t sb[$];
    exp_t e_pop;
    int   n_vec = 0;
    int   n_err = 0;
    logic prev_sv = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard consumer: every rising stats_valid retires one expected tile
    always @(negedge clk) begin
        if (reset && stats_valid && !prev_sv) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", 64'd1, 64'd0);
            end else begin
                e_pop = sb.pop_front();
                chk("mean", mean, e_pop.m);
                chk("inv_var", inv_var, e_pop.iv);
                chk("latency", 64'(cyc - e_pop.e0), 64'(e_pop.lat));
            end
        end
        prev_sv = stats_valid;
    end

    // Reference statistics straight from the arithmetic definition
    function automatic void model(input longint s, input longint ss, input int c,
                                  output logic [15:0] m, output logic [15:0] iv,
                                  output int lat);
        longint mag, mv, msq, ex2, v, v8, q;
        logic signed [15:0] ms;
        if (c == 0) begin
            m = 16'h0000; iv = 16'h0100; lat = 1;
        end else begin
            mag = ((s < 0) ? -s : s) / c;
            mv  = (s < 0) ? -mag : mag;
            m   = mv[15:0];
            ms  = m;
            msq = longint'(ms) * longint'(ms);
            ex2 = ss / c;
            v   = ex2 - msq;
            if (v < 0) v = 0;
            v8 = (v >> 8) & 64'hFFFFFF;
            if (v8 == 0) begin
                iv = 16'hFFFF; lat = 99;
            end else begin
                q   = 65536 / v8;
                iv  = (q > 65535) ? 16'hFFFF : q[15:0];
                lat = 148;
            end
        end
    endfunction

    // Drives a full tile; returns at the negedge where the final column is
    // presented (the following posedge samples it: that edge is e0).
    task automatic drive_tile(input logic [511:0] col, input logic [31:0] msk,
                              input bit gaps, input bit rnd,
                              output logic [15:0] mm, output logic [15:0] mi,
                              output int ml, output int e0);
        longint s = 0, ss = 0;
        int c = 0;
        logic [511:0] d;
        logic signed [15:0] lv;
        for (int k = 0; k < DESIGN_SIZE; k++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                @(negedge clk);
                in_data_available = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            d = col;
            if (rnd)
                for (int i = 0; i < DESIGN_SIZE; i++) d[i*16 +: 16] = 16'($urandom);
            @(negedge clk);
            in_data_available = 1'b1;
            inp_data          = d;
            validity_mask     = msk;
            for (int i = 0; i < DESIGN_SIZE; i++) begin
                if (msk[i]) begin
                    lv = d[i*16 +: 16];
                    s  += longint'(lv);
                    ss += longint'(lv) * longint'(lv);
                    c++;
                end
            end
        end
        e0 = cyc + 1;
        model(s, ss, c, mm, mi, ml);
    endtask

    task automatic go_idle();
        @(negedge clk);
        in_data_available = 1'b0;
        inp_data          = '0;
        validity_mask     = '0;
    endtask

    task automatic push(input logic [15:0] m, input logic [15:0] iv, input int lat, input int e0);
        exp_t e;
        e.m = m; e.iv = iv; e.lat = lat; e.e0 = e0;
        sb.push_back(e);
    endtask

    task automatic wait_sb();
        int t = 0;
        while (sb.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            chk("sb_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    // Results must hold in DONE (ignoring stray columns), then clear on disable
    task automatic release_tile(input logic [15:0] m, input logic [15:0] iv);
        @(negedge clk);
        in_data_available = 1'b1;
        inp_data          = {DESIGN_SIZE{16'h1234}};
        validity_mask     = '1;
        @(negedge clk);
        in_data_available = 1'b0;
        repeat (2) @(negedge clk);
        chk("hold_valid", stats_valid, 1);
        chk("hold_mean", mean, m);
        chk("hold_inv", inv_var, iv);
        chk("done_stats", done_stats, 1);
        enable_stats = 1'b0;
        @(negedge clk);
        chk("dis_valid", stats_valid, 0);
        chk("dis_mean", mean, 0);
        chk("dis_inv", inv_var, 0);
        chk("bypass_done", done_stats, 1);
        enable_stats = 1'b1;
    endtask

    logic [511:0] col_a, col_b, col_c, col_d;
    logic [15:0]  mm, mi;
    int           ml, e0;
    logic [31:0]  rmask;

    initial begin
        for (int i = 0; i < DESIGN_SIZE; i++) begin
            col_a[i*16 +: 16] = (i % 2 == 0) ? 16'h0000 : 16'h0400;
            col_b[i*16 +: 16] = (i % 2 == 0) ? 16'hFF00 : 16'h0100;
            col_c[i*16 +: 16] = (i < 16) ? 16'h0100 : 16'h7F00;
            col_d[i*16 +: 16] = 16'h0300;
        end

        reset             = 1'b0;
        enable_stats      = 1'b1;
        in_data_available = 1'b0;
        inp_data          = '0;
        validity_mask     = '0;
        #3;
        chk("rst_valid", stats_valid, 0);
        chk("rst_mean", mean, 0);
        chk("rst_inv", inv_var, 0);
        chk("rst_done", done_stats, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Alternating 0 / 4.0
        drive_tile(col_a, '1, 0, 0, mm, mi, ml, e0);
        push(16'h0200, 16'h0040, 148, e0);
        go_idle(); wait_sb(); release_tile(16'h0200, 16'h0040);

        // Same tile with gaps
        drive_tile(col_a, '1, 1, 0, mm, mi, ml, e0);
        push(16'h0200, 16'h0040, 148, e0);
        go_idle(); wait_sb(); release_tile(16'h0200, 16'h0040);

        // Alternating -1.0 / +1.0
        drive_tile(col_b, '1, 0, 0, mm, mi, ml, e0);
        push(16'h0000, 16'h0100, 148, e0);
        go_idle(); wait_sb(); release_tile(16'h0000, 16'h0100);

        // Masked-off outliers, zero variance
        drive_tile(col_c, 32'h0000FFFF, 0, 0, mm, mi, ml, e0);
        push(16'h0100, 16'hFFFF, 99, e0);
        go_idle(); wait_sb(); release_tile(16'h0100, 16'hFFFF);

        // Empty mask, back-to-back and with gaps
        drive_tile(col_a, '0, 0, 0, mm, mi, ml, e0);
        push(16'h0000, 16'h0100, 1, e0);
        go_idle(); wait_sb(); release_tile(16'h0000, 16'h0100);
        drive_tile(col_a, '0, 1, 0, mm, mi, ml, e0);
        push(16'h0000, 16'h0100, 1, e0);
        go_idle(); wait_sb(); release_tile(16'h0000, 16'h0100);

        // Random data and mask, reference model
        for (int t = 0; t < 2; t++) begin
            rmask = $urandom;
            drive_tile('0, rmask, t[0], 1, mm, mi, ml, e0);
            push(mm, mi, ml, e0);
            go_idle(); wait_sb(); release_tile(mm, mi);
        end

        // Abort during DIV_SQ, then a fresh tile
        drive_tile(col_a, '1, 0, 0, mm, mi, ml, e0);
        go_idle();
        repeat (70) @(negedge clk);
        chk("divsq_mean", mean, 16'h0200);
        chk("divsq_valid", stats_valid, 0);
        enable_stats = 1'b0;
        @(negedge clk);
        chk("abort_valid", stats_valid, 0);
        chk("abort_mean", mean, 0);
        chk("abort_inv", inv_var, 0);
        chk("abort_done", done_stats, 1);
        enable_stats = 1'b1;
        rmask = $urandom;
        drive_tile('0, rmask, 0, 1, mm, mi, ml, e0);
        push(mm, mi, ml, e0);
        go_idle(); wait_sb(); release_tile(mm, mi);

        // Async reset while results are held
        drive_tile(col_a, '1, 0, 0, mm, mi, ml, e0);
        push(16'h0200, 16'h0040, 148, e0);
        go_idle(); wait_sb();
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_done_valid", stats_valid, 0);
        chk("arst_done_mean", mean, 0);
        chk("arst_done_inv", inv_var, 0);
        #4 reset = 1'b1;

        // Async reset mid-accumulation; the partial tile must be discarded
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_data_available = 1'b1;
            inp_data          = {DESIGN_SIZE{16'h7000}};
            validity_mask     = '1;
        end
        @(negedge clk);
        in_data_available = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("arst_acc_valid", stats_valid, 0);
        chk("arst_acc_mean", mean, 0);
        chk("arst_acc_inv", inv_var, 0);
        #4 reset = 1'b1;
        drive_tile(col_d, '1, 0, 0, mm, mi, ml, e0);
        push(16'h0300, 16'hFFFF, 99, e0);
        go_idle(); wait_sb(); release_tile(16'h0300, 16'hFFFF);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/norm_stats.md
# norm_stats

Computes the batch statistics consumed by the `norm` block, producing its `mean` and `inv_var` inputs. It observes the same column stream (`inp_data`, `in_data_available`, `validity_mask`) over one `DESIGN_SIZE`-column tile and accumulates the sum and sum-of-squares of all valid lanes. A shared serial divider then produces the mean and inverse variance in Q8.8 format. The block sits upstream of `norm` on the systolic output path and is enabled per tile by the controller.

## Interface
- `DESIGN_SIZE`, 32, lanes per column and columns per tile
- `DWIDTH`, 16, element width, signed Q8.8
- `MASK_WIDTH`, 32, validity mask width (= `DESIGN_SIZE`)
- `DIV_W`, 48, divider dividend/quotient width
- `clk`, input, 1, single clock; all state on rising edge
- `reset`, input, 1, asynchronous, active-low; all state and outputs cleared while low
- `enable_stats`, input, 1, level enable; low forces IDLE synchronously
- `in_data_available`, input, 1, column valid this cycle
- `inp_data`, input, `DESIGN_SIZE*DWIDTH`, one column; lane i at `[i*DWIDTH +: DWIDTH]`
- `validity_mask`, input, `MASK_WIDTH`, bit i=1 includes lane i; sampled per column
- `mean`, output, `DWIDTH`, signed Q8.8 mean; reset 0
- `inv_var`, output, `DWIDTH`, unsigned Q8.8 1/variance; reset 0
- `stats_valid`, output, 1, `mean`/`inv_var` valid; reset 0
- `done_stats`, output, 1, equals `stats_valid`, or 1 when `enable_stats`=0 (bypass, like `done_norm`)

## Operation
- States: IDLE, ACCUM, DIV_MEAN, DIV_SQ, VAR, DIV_INV, DONE.
- IDLE: on `in_data_available`=1, accumulate that column, set col_cnt=1, go to ACCUM.
- ACCUM: each valid column adds every masked lane to `sum` (signed, 27 b) and `lane*lane` to `sumsq` (unsigned, 42 b), and adds popcount(mask) to `count` (11 b). Gaps, where `in_data_available`=0, are allowed and hold state. When the `DESIGN_SIZE`-th column is sampled:
  - if `count`=0, go to DONE with `mean`=0 and `inv_var`=0x0100;
  - otherwise go to DIV_MEAN.
- DIV_MEAN: compute |sum|/count and negate if `sum`<0 (truncate toward zero). Latch the low `DWIDTH` bits as `mean`.
- DIV_SQ: compute `ex2` = sumsq/count (Q16.16).
- VAR (1 cycle):
  - `var16` = `ex2` − `mean`², clamped at 0;
  - `var8` = `var16`>>8 (24 b).
  - If `var8`=0, set `inv_var`=0xFFFF and go to DONE. Otherwise go to DIV_INV.
- DIV_INV: compute q = 65536/var8. `inv_var` = q, saturated to 0xFFFF.
- DONE: `stats_valid`=1. Outputs are held until `enable_stats`=0. Columns arriving in DONE or any DIV state are ignored.
- `enable_stats`=0 in any state: next edge goes to IDLE, clears accumulators, and sets `stats_valid`=0. `mean`/`inv_var` are cleared too.

## Timing
- The divider is unsigned restoring, 1 quotient bit per cycle. It is started on the first cycle of each DIV state, and its quotient is valid after exactly `DIV_W` cycles. Each DIV state therefore occupies `DIV_W`+1 = 49 cycles.
- With edge E0 sampling the final column, `stats_valid` rises at edge E0+148 (49+49+1+49).
- If `var8`=0, it rises at E0+99.
- If `count`=0, it rises at E0+1.
- The accumulation path adds no latency: column k is summed on the edge that samples it.
- Async reset mid-operation: outputs are 0 immediately. After release, the block waits in IDLE for a fresh first column.
- Simultaneous `enable_stats` falling and last column: abort wins, so the block goes to IDLE.

## Structure
- Shared defines file (existing): `DWIDTH`, `DESIGN_SIZE`, `MASK_WIDTH`, `LOG2_DESIGN_SIZE`.
- Local state encoding as localparams; the Q8.8 constants (0x0100, 0xFFFF, 65536) are named constants in the same shared file.
- One sub-module: `norm_stats_div`, a serial unsigned divider.
  - Ports: `clk`, `reset`, `start`, dividend[`DIV_W`], divisor[24], quotient[`DIV_W`], `div_done`.
  - Divide-by-zero returns all ones; the parent guards against it.

## Test plan
- Mask all ones; even lanes 0x0000, odd lanes 0x0400; 32 back-to-back columns -> `mean`=0x0200, `inv_var`=0x0040, `stats_valid` at E0+148.
- Mask all ones; even lanes 0xFF00 (−1.0), odd lanes 0x0100 -> `mean`=0x0000, `inv_var`=0x0100.
- Mask 0x0000FFFF; lanes 0–15 = 0x0100, lanes 16–31 = 0x7F00 -> `mean`=0x0100, `inv_var`=0xFFFF (zero variance), `stats_valid` at E0+99.
- Mask 0 for all columns -> `mean`=0, `inv_var`=0x0100, `stats_valid` at E0+1. Random gaps in `in_data_available` give identical results.
- `enable_stats` dropped during DIV_SQ -> next edge `stats_valid`=0, `mean`=`inv_var`=0, `done_stats`=1. Re-enable with a new tile -> correct new statistics.
- Assert `reset` low mid-ACCUM (not on an edge) -> outputs 0 immediately. After release, a full tile of 0x0300 gives `mean`=0x0300, `inv_var`=0xFFFF.
